dbus_sram_responder: RTL and testbench
======================================

// Module: dbus_sram_responder
// PURPOSE
//   Responder (slave) end of the dbus_req_t/dbus_resp_t interface driven by the core.
//   Accepts one outstanding load/store, models fixed memory latency and services it from
//   an internal word-addressed SRAM array with byte strobes.
//   Sits between the core's dreq output and the testbench memory image in simulation tops.
// PARAMETERS
//   MEM_WORDS  1024  depth of SRAM in 32-bit words; power of two, >= 2
//   LATENCY    2     idle cycles between accept and data_ok; 0..15
// PORTS
//   clk        in   1    clock, all state on posedge
//   resetn     in   1    asynchronous, active-low reset
//   dreq       in   dbus_req_t  {valid, addr[31:0], size msize_t[2:0], strobe[3:0], data[31:0]}
//   dresp      out  dbus_resp_t {addr_ok, data_ok, data[31:0]}
//   misalign   out  1    pulses with data_ok when the completed request was misaligned
//   txn_count  out  32   number of completed transactions (data_ok pulses) since reset
// BEHAVIOUR
// - Reset (resetn=0, async): state=IDLE, dresp all 0, misalign=0, txn_count=0, latched
//   request cleared. SRAM contents NOT cleared. Reset mid-transaction abandons it; no write.
// - States: IDLE, WAIT, RESP.
//   IDLE: addr_ok = dreq.valid (combinational). Accept edge (valid&&addr_ok) latches
//     addr/size/strobe/data, loads cnt=LATENCY; -> WAIT if LATENCY>0, else -> RESP.
//   WAIT: addr_ok=0; cnt decrements each cycle; cnt==1 -> RESP.
//   RESP: data_ok=1 for exactly this cycle; addr_ok = dreq.valid (back-to-back accept).
//     Next: accept -> WAIT/RESP as in IDLE; else -> IDLE.
// - Timing: accept at edge ending cycle t => data_ok high in cycle t+1+LATENCY.
// - Throughput: back-to-back one txn per LATENCY+1 cycles; addr_ok never asserted in WAIT.
// - Index = addr[$clog2(MEM_WORDS)+1:2]; upper address bits ignored (aliasing wrap).
// - Alignment: size MSIZE1 any addr; MSIZE2 needs addr[0]==0; MSIZE4 needs addr[1:0]==0.
// - Read (strobe==0): dresp.data = full SRAM word at index during RESP; byte lane
//   extraction is the core's job. Non-RESP cycles: dresp.data = 0.
// - Write (strobe!=0): bytes with strobe[i]=1 take latched data[8i+7:8i], committed on
//   the RESP-exit edge; dresp.data in RESP = pre-write word. Read accepted in the same
//   RESP cycle observes the new word (its data is read later).
// - Misaligned: no SRAM write; dresp.data = 32'hDEAD_BEEF; misalign=1 with data_ok.
// - txn_count increments on every data_ok cycle (incl. misaligned); wraps at 2^32.
// - dreq fields required stable while valid && !addr_ok; only valid/fields at accept
//   edge matter; dreq changes during WAIT ignored.
// - Read-only debug port: none; SRAM initialised by $readmemh from the sim harness.
// TESTING
// 1. LATENCY=2: reset, valid read addr 0x10 (word 4 = 0x11223344) in cycle 0 -> addr_ok
//    cycle 0, data_ok+data=0x11223344 cycle 3, txn_count=1.
// 2. Store addr 0x21 MSIZE1 strobe 4'b0010 data 0x0000AB00 onto word 0x8=0xFFFFFFFF ->
//    later read of 0x20 returns 0xFFFFABFF.
// 3. Back-to-back: valid held for 3 reads -> addr_ok in cycles 0,3,6; data_ok in 3,6,9.
// 4. Store MSIZE4 addr 0x42 -> data_ok with data=0xDEADBEEF, misalign=1, word 0x10 unchanged.
// 5. Store accepted, resetn pulsed low during WAIT -> outputs 0 at once, txn_count=0,
//    target word unchanged; next request served normally.
// 6. LATENCY=0, MEM_WORDS=1024: read addr 0x1000 -> aliases to word 0, data_ok next cycle.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// Responder end of the core data bus: one outstanding load/store with fixed latency,
// serviced from a word-addressed SRAM with byte strobes.

package dbus_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic        misalign,
    output logic [31:0] txn_count
);

    localparam int unsigned IdxW   = $clog2(MEM_WORDS);
    localparam logic [3:0]  LatCnt = 4'(LATENCY);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // With zero latency the accepted request is answered in the very next cycle.
    localparam state_e AcceptNext = (LATENCY > 0) ? StWait : StResp;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    msize_t      size_q;
    logic [3:0]  strobe_q;
    logic [31:0] data_q;
    logic [31:0] txn_count_q;

    logic [31:0] mem [MEM_WORDS];

    logic            accept;
    logic            mis_c;
    logic            resp_c;
    logic            wr_en;
    logic [IdxW-1:0] idx;
    logic            unused_addr;

    // Upper address bits alias onto the array.
    assign idx         = addr_q[IdxW+1:2];
    assign unused_addr = ^addr_q[31:IdxW+2];

    assign resp_c = (state_q == StResp);
    // addr_ok is never raised while the latency counter is running.
    assign accept = dreq.valid && (state_q != StWait);
    assign wr_en  = resp_c && !mis_c && (strobe_q != 4'b0000);

    // Alignment check of the latched request; unknown sizes are held to word alignment.
    always_comb begin
        mis_c = 1'b0;
        case (size_q)
            MSIZE1:  mis_c = 1'b0;
            MSIZE2:  mis_c = addr_q[0];
            default: mis_c = |addr_q[1:0];
        endcase
    end

    // Response outputs: data only in the RESP cycle, pre-write word for stores.
    always_comb begin
        dresp.addr_ok = accept;
        dresp.data_ok = resp_c;
        dresp.data    = 32'h0;
        if (resp_c) begin
            dresp.data = mis_c ? 32'hDEAD_BEEF : mem[idx];
        end
        misalign  = resp_c && mis_c;
        txn_count = txn_count_q;
    end

    // Control FSM: accept, count down latency, respond, and count completions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            size_q      <= MSIZE1;
            strobe_q    <= 4'b0000;
            data_q      <= 32'h0;
            txn_count_q <= 32'h0;
        end else begin
            if (resp_c) begin
                txn_count_q <= txn_count_q + 32'd1;
            end
            unique case (state_q)
                StIdle, StResp: begin
                    if (accept) begin
                        addr_q   <= dreq.addr;
                        size_q   <= dreq.size;
                        strobe_q <= dreq.strobe;
                        data_q   <= dreq.data;
                        cnt_q    <= LatCnt;
                        state_q  <= AcceptNext;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StResp;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Store commit on the edge leaving RESP; a reset forces the FSM out of RESP first.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe_q[i]) begin
                    mem[idx][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench: one instance with LATENCY=2, one with LATENCY=0, sharing clock and reset.

module tb_dbus_sram_responder;
    import dbus_pkg::*;

    logic        clk;
    logic        resetn;
    dbus_req_t   dreq  [2];
    dbus_resp_t  dresp [2];
    logic        mis   [2];
    logic [31:0] cnt   [2];

    int unsigned lat [2] = '{2, 0};
    int unsigned exp_cnt [2] = '{0, 0};
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          dut;
        bit          wr;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
        bit          chk;
        logic [31:0] exp;
        bit          exp_mis;
    } vec_t;

    vec_t tbl [$];

    dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(2)) u_dut0 (
        .clk       (clk),
        .resetn    (resetn),
        .dreq      (dreq[0]),
        .dresp     (dresp[0]),
        .misalign  (mis[0]),
        .txn_count (cnt[0])
    );

    dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(0)) u_dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .dreq      (dreq[1]),
        .dresp     (dresp[1]),
        .misalign  (mis[1]),
        .txn_count (cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input int d, input bit wr, input logic [31:0] a, input msize_t s,
                                input logic [3:0] st, input logic [31:0] dat, input bit c,
                                input logic [31:0] e, input bit m);
        vec_t v;
        v.dut = d; v.wr = wr; v.addr = a; v.size = s; v.strobe = st; v.data = dat;
        v.chk = c; v.exp = e; v.exp_mis = m;
        return v;
    endfunction

    // One isolated transaction: drive, wait for accept, then time the response.
    task automatic run_txn(input vec_t v, input string tag);
        int s = v.dut;
        int w;
        int n;
        @(posedge clk); #1;
        dreq[s].valid  = 1'b1;
        dreq[s].addr   = v.addr;
        dreq[s].size   = v.size;
        dreq[s].strobe = v.wr ? v.strobe : 4'b0000;
        dreq[s].data   = v.data;
        w = 0;
        @(negedge clk);
        while (!dresp[s].addr_ok && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " accept_wait"}, w, 0);
        @(posedge clk); #1;
        dreq[s].valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dresp[s].data_ok && n < 30);
        chk({tag, " latency"}, n, lat[s] + 1);
        if (v.chk) chk({tag, " data"}, dresp[s].data, v.exp);
        chk({tag, " misalign"}, {31'd0, mis[s]}, {31'd0, v.exp_mis});
        chk({tag, " txn_count"}, cnt[s], exp_cnt[s]);
        exp_cnt[s]++;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            exp_cnt[s] = 0;
            chk($sformatf("reset%0d resp", s), {30'd0, dresp[s].addr_ok, dresp[s].data_ok},
                32'd0);
            chk($sformatf("reset%0d data", s), dresp[s].data, 32'h0);
            chk($sformatf("reset%0d misalign", s), {31'd0, mis[s]}, 32'd0);
            chk($sformatf("reset%0d txn_count", s), cnt[s], 32'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [11:0] ok_mask;
        logic [11:0] dok_mask;
        logic [31:0] got [3];
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_exp  [3];
        int k;
        int j;

        resetn = 1'b0;
        dreq[0] = '0;
        dreq[1] = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Preload memory image through ordinary stores.
        run_txn(mk(0, 1, 32'h10, MSIZE4, 4'hF, 32'h1122_3344, 0, 0, 0), "pre0");
        run_txn(mk(0, 1, 32'h20, MSIZE4, 4'hF, 32'hFFFF_FFFF, 0, 0, 0), "pre1");
        run_txn(mk(0, 1, 32'h40, MSIZE4, 4'hF, 32'h5566_7788, 0, 0, 0), "pre2");

        // Reset must clear outputs and the counter but not the array.
        reset_pulse();

        tbl.push_back(mk(0, 0, 32'h10,   MSIZE4, 4'h0, 32'h0,         1, 32'h1122_3344, 0));
        tbl.push_back(mk(0, 1, 32'h21,   MSIZE1, 4'h2, 32'h0000_AB00, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, 0, 32'h20,   MSIZE4, 4'h0, 32'h0,         1, 32'hFFFF_ABFF, 0));
        tbl.push_back(mk(0, 1, 32'h42,   MSIZE4, 4'hF, 32'h1234_5678, 1, 32'hDEAD_BEEF, 1));
        tbl.push_back(mk(0, 0, 32'h40,   MSIZE4, 4'h0, 32'h0,         1, 32'h5566_7788, 0));
        tbl.push_back(mk(0, 0, 32'h41,   MSIZE2, 4'h0, 32'h0,         1, 32'hDEAD_BEEF, 1));
        tbl.push_back(mk(0, 0, 32'h42,   MSIZE2, 4'h0, 32'h0,         1, 32'h5566_7788, 0));
        tbl.push_back(mk(0, 1, 32'h12,   MSIZE2, 4'hC, 32'hCAFE_0000, 1, 32'h1122_3344, 0));
        tbl.push_back(mk(0, 0, 32'h1010, MSIZE4, 4'h0, 32'h0,         1, 32'hCAFE_3344, 0));
        tbl.push_back(mk(0, 0, 32'h23,   MSIZE1, 4'h0, 32'h0,         1, 32'hFFFF_ABFF, 0));
        tbl.push_back(mk(1, 1, 32'h0,    MSIZE4, 4'hF, 32'hA5A5_0001, 0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 32'h1000, MSIZE4, 4'h0, 32'h0,         1, 32'hA5A5_0001, 0));
        tbl.push_back(mk(1, 1, 32'h1,    MSIZE2, 4'h3, 32'h0000_FFFF, 1, 32'hDEAD_BEEF, 1));
        tbl.push_back(mk(1, 0, 32'h0,    MSIZE4, 4'h0, 32'h0,         1, 32'hA5A5_0001, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back reads with valid held: one accept every LATENCY+1 cycles.
        b2b_addr = '{32'h10, 32'h20, 32'h40};
        b2b_exp  = '{32'hCAFE_3344, 32'hFFFF_ABFF, 32'h5566_7788};
        ok_mask  = '0;
        dok_mask = '0;
        got      = '{32'h0, 32'h0, 32'h0};
        k = 0;
        j = 0;
        @(posedge clk); #1;
        dreq[0].valid  = 1'b1;
        dreq[0].addr   = b2b_addr[0];
        dreq[0].size   = MSIZE4;
        dreq[0].strobe = 4'b0000;
        for (int c = 0; c < 12; c++) begin
            logic ok_now;
            @(negedge clk);
            ok_now = dresp[0].addr_ok;
            ok_mask[c] = ok_now;
            if (dresp[0].data_ok) begin
                dok_mask[c] = 1'b1;
                if (j < 3) got[j] = dresp[0].data;
                j++;
            end
            @(posedge clk); #1;
            if (ok_now && dreq[0].valid) begin
                k++;
                if (k < 3) dreq[0].addr = b2b_addr[k];
                else dreq[0].valid = 1'b0;
            end
        end
        dreq[0].valid = 1'b0;
        chk("b2b addr_ok cycles", {20'd0, ok_mask}, 32'h0000_0049);
        chk("b2b data_ok cycles", {20'd0, dok_mask}, 32'h0000_0248);
        for (int i = 0; i < 3; i++) chk($sformatf("b2b data%0d", i), got[i], b2b_exp[i]);
        exp_cnt[0] += 3;
        chk("b2b txn_count", cnt[0], exp_cnt[0]);

        // Reset while a store is waiting: abandoned, no write.
        @(posedge clk); #1;
        dreq[0].valid  = 1'b1;
        dreq[0].addr   = 32'h20;
        dreq[0].size   = MSIZE4;
        dreq[0].strobe = 4'hF;
        dreq[0].data   = 32'h0101_0101;
        @(negedge clk);
        chk("rstwait accept", {31'd0, dresp[0].addr_ok}, 32'd1);
        @(posedge clk); #1;
        dreq[0].valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        chk("rstwait resp", {30'd0, dresp[0].addr_ok, dresp[0].data_ok}, 32'd0);
        chk("rstwait data", dresp[0].data, 32'h0);
        chk("rstwait txn_count", cnt[0], 32'd0);
        @(negedge clk);
        @(posedge clk); #2;
        resetn = 1'b1;
        run_txn(mk(0, 0, 32'h20, MSIZE4, 4'h0, 32'h0, 1, 32'hFFFF_ABFF, 0), "rstwait read");

        // LATENCY=0: store then read of the same word accepted in its RESP cycle.
        @(posedge clk); #1;
        dreq[1].valid  = 1'b1;
        dreq[1].addr   = 32'h4;
        dreq[1].size   = MSIZE4;
        dreq[1].strobe = 4'hF;
        dreq[1].data   = 32'h0BAD_F00D;
        @(negedge clk);
        chk("l0 wr accept", {31'd0, dresp[1].addr_ok}, 32'd1);
        @(posedge clk); #1;
        dreq[1].strobe = 4'h0;
        dreq[1].data   = 32'h0;
        @(negedge clk);
        chk("l0 wr resp", {30'd0, dresp[1].addr_ok, dresp[1].data_ok}, 32'd3);
        @(posedge clk); #1;
        dreq[1].valid = 1'b0;
        @(negedge clk);
        chk("l0 rd data_ok", {31'd0, dresp[1].data_ok}, 32'd1);
        chk("l0 rd data", dresp[1].data, 32'h0BAD_F00D);
        chk("l0 rd txn_count", cnt[1], exp_cnt[1] + 1);
        exp_cnt[1] += 2;
        @(negedge clk);
        chk("l0 final txn_count", cnt[1], exp_cnt[1]);
        chk("l0 idle data_ok", {31'd0, dresp[1].data_ok}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
